// File: rtl/shift_seq32.sv
// Multi-cycle 32-bit shifter for the ALU32 shifter path.
// Supports SLL/SRL/SRA/ROR, up to STEP bit positions per clock, with valid/ready on both sides.
module shift_seq32 #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out,
    output logic        zero
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam logic [4:0] STEP_W = 5'(STEP);

    logic [1:0]  state;
    logic [1:0]  cur_op;
    logic [31:0] work;
    logic [4:0]  remaining;
    logic        sign;

    logic [4:0]  k;
    logic [31:0] shr;
    logic [31:0] shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One step of the working register; k is never zero while in SHIFT.
    always_comb begin
        k   = (remaining < STEP_W) ? remaining : STEP_W;
        shr = work >> k;
        case (cur_op)
            OP_SLL:  shifted = work << k;
            OP_SRL:  shifted = shr;
            OP_SRA:  shifted = sign ? (shr | ~(32'hFFFF_FFFF >> k)) : shr;
            default: shifted = shr | (work << (6'd32 - {1'b0, k}));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_op    <= 2'b00;
            work      <= 32'h0;
            remaining <= 5'd0;
            sign      <= 1'b0;
            Out       <= 32'h0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_op    <= op;
                        work      <= In1;
                        remaining <= In2[4:0];
                        sign      <= In1[31];
                        if (In2[4:0] == 5'd0) begin
                            Out   <= In1;
                            zero  <= (In1 == 32'h0);
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    // Last step: remaining drops to zero on this edge.
                    if (remaining == k) begin
                        Out   <= shifted;
                        zero  <= (shifted == 32'h0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq32.sv
// Self-checking bench for shift_seq32: directed cases on STEP=4, random sweeps on STEP=1 and STEP=16.
// Instance 0 uses STEP=4, instance 1 STEP=1, instance 2 STEP=16; all share clock and reset.
module tb_shift_seq32;

    logic        clk;
    logic        rst_n;
    logic        in_valid_w  [3];
    logic        in_ready_w  [3];
    logic [1:0]  op_w        [3];
    logic [31:0] in1_w       [3];
    logic [31:0] in2_w       [3];
    logic        out_valid_w [3];
    logic        out_ready_w [3];
    logic [31:0] out_w       [3];
    logic        zero_w      [3];

    int checks;
    int errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_seq32 #(.STEP(g == 0 ? 4 : (g == 1 ? 1 : 16))) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_w[g]),
            .in_ready  (in_ready_w[g]),
            .op        (op_w[g]),
            .In1       (in1_w[g]),
            .In2       (in2_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready_w[g]),
            .Out       (out_w[g]),
            .zero      (zero_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the combinational definition of each operation.
    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int amt;
        logic [31:0] r;
        amt = int'(b % 32);
        case (o)
            2'b00:   r = a << amt;
            2'b01:   r = a >> amt;
            2'b10:   r = $signed(a) >>> amt;
            default: r = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an operation, wait for acceptance, then count cycles until out_valid.
    task automatic applyStimulus(input int d, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready_w[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready_w[d]), 32'd1);
        in_valid_w[d] = 1'b1;
        op_w[d]       = o;
        in1_w[d]      = a;
        in2_w[d]      = b;
        @(posedge clk);
        #1;
        in_valid_w[d] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (out_valid_w[d] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input int d, input logic [31:0] expOut,
                               input logic expZero, input int expLat, input int lat);
        check({tag, "_valid"}, 32'(out_valid_w[d]), 32'd1);
        check({tag, "_out"}, out_w[d], expOut);
        check({tag, "_zero"}, 32'(zero_w[d]), 32'(expZero));
        check({tag, "_lat"}, 32'(lat), 32'(expLat));
    endtask

    // Consume the result; out_ready is restored to whatever it was before.
    task automatic consume(input string tag, input int d, input logic [31:0] expOut);
        logic prev;
        prev = out_ready_w[d];
        out_ready_w[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_w[d] = prev;
        check({tag, "_drop"}, 32'(out_valid_w[d]), 32'd0);
        check({tag, "_idle"}, 32'(in_ready_w[d]), 32'd1);
        check({tag, "_hold"}, out_w[d], expOut);
    endtask

    task automatic runOp(input string tag, input int d, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expOut, input logic expZero,
                         input int expLat);
        int lat;
        applyStimulus(d, o, a, b, lat);
        checkOutput(tag, d, expOut, expZero, expLat, lat);
        consume(tag, d, expOut);
    endtask

    initial begin
        int lat;
        int seen;
        int stepv;
        int amt;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_w[i]  = 1'b0;
            op_w[i]        = 2'b00;
            in1_w[i]       = 32'h0;
            in2_w[i]       = 32'h0;
            out_ready_w[i] = 1'b0;
        end
        #13;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready_w[i]), 32'd1);
            check("rst_out_valid", 32'(out_valid_w[i]), 32'd0);
            check("rst_out", out_w[i], 32'h0);
            check("rst_zero", 32'(zero_w[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed cases, STEP=4");
        runOp("srl31", 0, 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 9);
        runOp("sll_amt0", 0, 2'b00, 32'h0000_0001, 32'd32, 32'h0000_0001, 1'b0, 1);
        runOp("sra4", 0, 2'b10, 32'h8000_00F0, 32'd4, 32'hF800_000F, 1'b0, 2);
        runOp("ror1", 0, 2'b11, 32'h0000_0001, 32'd1, 32'h8000_0000, 1'b0, 2);
        runOp("sll3f", 0, 2'b00, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 9);
        runOp("srl_zero", 0, 2'b01, 32'h0000_000F, 32'd4, 32'h0000_0000, 1'b1, 2);
        runOp("srl_hi25", 0, 2'b01, 32'h1234_5678, 32'h0000_0025, 32'h0091_A2B3, 1'b0, 3);
        runOp("ror_nonzero", 0, 2'b11, 32'hF000_000F, 32'd8, 32'h0FF0_0000, 1'b0, 3);

        $display("[TB] reset during SHIFT");
        runOp("pre_rst", 0, 2'b00, 32'h0000_00AB, 32'd4, 32'h0000_0AB0, 1'b0, 2);
        @(negedge clk);
        in_valid_w[0] = 1'b1;
        op_w[0]       = 2'b01;
        in1_w[0]      = 32'hFFFF_0000;
        in2_w[0]      = 32'd20;
        @(posedge clk);
        #1;
        in_valid_w[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_shift_busy", 32'(in_ready_w[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid_w[0]), 32'd0);
        check("async_rst_out", out_w[0], 32'h0);
        check("async_rst_zero", 32'(zero_w[0]), 32'd0);
        check("async_rst_ready", 32'(in_ready_w[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_w[0] === 1'b1) seen++;
        end
        check("no_result_after_rst", 32'(seen), 32'd0);
        check("out_after_rst", out_w[0], 32'h0);

        $display("[TB] output backpressure");
        applyStimulus(0, 2'b00, 32'h0000_0003, 32'd2, lat);
        checkOutput("bp_first", 0, 32'h0000_000C, 1'b0, 2, lat);
        in_valid_w[0] = 1'b1;
        op_w[0]       = 2'b11;
        in1_w[0]      = 32'h0000_0001;
        in2_w[0]      = 32'd1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid_w[0]), 32'd1);
            check("bp_out", out_w[0], 32'h0000_000C);
            check("bp_zero", 32'(zero_w[0]), 32'd0);
            check("bp_ready", 32'(in_ready_w[0]), 32'd0);
        end
        out_ready_w[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_w[0] = 1'b0;
        check("bp_release_idle", 32'(in_ready_w[0]), 32'd1);
        check("bp_release_valid", 32'(out_valid_w[0]), 32'd0);
        @(posedge clk);
        #1;
        in_valid_w[0] = 1'b0;
        check("bp_next_accepted", 32'(in_ready_w[0]), 32'd0);
        lat = 1;
        @(negedge clk);
        while (out_valid_w[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_next", 0, 32'h8000_0000, 1'b0, 2, lat);
        consume("bp_next", 0, 32'h8000_0000);

        $display("[TB] random sweep, STEP=1 then STEP=16 (out_ready held high)");
        out_ready_w[2] = 1'b1;
        for (int d = 1; d < 3; d++) begin
            stepv = (d == 1) ? 1 : 16;
            for (int i = 0; i < 1000; i++) begin
                o = 2'($urandom_range(0, 3));
                a = $urandom;
                b = $urandom;
                if (i % 10 == 0) b = {$urandom, 5'd0} >> 5 << 5;
                if (i % 10 == 1) b = 32'd31;
                if (i % 10 == 2) a = 32'h0;
                e = refShift(o, a, b);
                amt = int'(b % 32);
                runOp((d == 1) ? "rand_s1" : "rand_s16", d, o, a, b, e, (e == 32'h0),
                      1 + (amt + stepv - 1) / stepv);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
